// File: rtl/lut_fn_pkg.sv
// Shared types and constants for the reloadable LUT function engine.
package lut_fn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam logic [15:0] LUT_FN_INIT4 = 16'h831B;

endpackage

// File: rtl/lut_fn_shadow.sv
// Shadow truth-table register written one bit at a time during a reload.
// Latency: write visible the cycle after we; no backpressure.
module lut_fn_shadow #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        idx,
    input  logic                din,
    input  logic                we,
    output logic [(1<<N)-1:0]   shadow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (we) begin
            shadow[idx] <= din;
        end
    end

endmodule

// File: rtl/lut_fn_engine.sv
// Programmable N-input Boolean function: registered eval, glitch-free serial reload, minterm sweep.
// Latency: eval 1 cycle, sweep DEPTH+1 cycles; in_ready drops while loading or sweeping.
module lut_fn_engine
    import lut_fn_pkg::*;
#(
    parameter int                N    = 4,
    parameter logic [(1<<N)-1:0] INIT = LUT_FN_INIT4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_a,
    output logic         in_ready,
    output logic         z,
    output logic         z_valid,
    input  logic         ld_start,
    input  logic         ld_valid,
    input  logic         ld_bit,
    input  logic         sweep_start,
    output logic         busy,
    output logic [N:0]   ones_cnt,
    output logic         cnt_valid
);

    localparam int         DEPTH       = 1 << N;
    localparam logic [N:0] IDX_ONE     = {{N{1'b0}}, 1'b1};
    localparam logic [N:0] IDX_LAST_LD = {1'b0, {N{1'b1}}};
    localparam logic [N:0] IDX_DONE    = {1'b1, {N{1'b0}}};

    state_t             state;
    logic [N:0]         idx;
    logic [N:0]         acc;
    logic [DEPTH-1:0]   table_q;
    logic [DEPTH-1:0]   shadow_vec;
    logic [DEPTH-1:0]   commit_vec;
    logic               shadow_we;

    assign busy      = (state != IDLE);
    assign in_ready  = ~busy;
    assign shadow_we = (state == LOAD) && ld_valid;

    lut_fn_shadow #(.N(N)) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .idx    (idx[N-1:0]),
        .din    (ld_bit),
        .we     (shadow_we),
        .shadow (shadow_vec)
    );

    // The final bit is merged here so the whole new table lands on one edge.
    always_comb begin
        commit_vec            = shadow_vec;
        commit_vec[DEPTH-1]   = ld_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            table_q   <= INIT;
            z         <= 1'b0;
            z_valid   <= 1'b0;
            ones_cnt  <= '0;
            cnt_valid <= 1'b0;
        end else begin
            z_valid   <= 1'b0;
            cnt_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z       <= table_q[in_a];
                        z_valid <= 1'b1;
                    end
                    if (ld_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end else if (sweep_start) begin
                        state <= SWEEP;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        if (idx == IDX_LAST_LD) begin
                            table_q <= commit_vec;
                            idx     <= '0;
                            state   <= IDLE;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                SWEEP: begin
                    if (idx == IDX_DONE) begin
                        ones_cnt  <= acc;
                        cnt_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        acc <= acc + {{N{1'b0}}, table_q[idx[N-1:0]]};
                        idx <= idx + IDX_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
